// File: rtl/fx_pt_acc_rnd_reg.sv
// fx_pt_acc_rnd_reg
//   Fixed-point frame accumulator. Adds N valid samples at full precision and
//   then rounds the frame total to SFW fraction bits, using round-half-away-from-zero.
//   The rounded result is registered and announced with a one-cycle out_vld pulse.
//   Number modes (SN): 0 unsigned, 1 two's complement, 2 sign-magnitude.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   clr      in   synchronous frame abort; any sample in the same cycle is dropped
//   in_vld   in   in_a is valid this cycle
//   in_a     in   input sample, IIW.IFW in mode SN
//   sum      out  rounded frame total, SIW.SFW in mode SN, held until the next frame
//   out_vld  out  one-cycle pulse when sum updates
//   busy     out  a frame is partially accumulated
//   ovf      out  the current sum was saturated (constant 0 unless FX_PT_SAT_EN)
//
// Build option
//   FX_PT_SAT_EN  out-of-range totals saturate and raise ovf; otherwise they wrap
//                 modulo 2^(SIW+SFW).

module fx_pt_acc_rnd_reg #(
    parameter int SN  = 1,
    parameter int IIW = 4,
    parameter int IFW = 8,
    parameter int N   = 16,
    parameter int SIW = IIW + $clog2(N) + 1,
    parameter int SFW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_vld,
    input  logic [IIW+IFW-1:0]   in_a,
    output logic [SIW+SFW-1:0]   sum,
    output logic                 out_vld,
    output logic                 busy,
    output logic                 ovf
);

    localparam int IW = IIW + IFW;
    localparam int CW = $clog2(N);
    localparam int AW = IW + CW + 1;
    localparam int OW = SIW + SFW;
    localparam int SH = (SFW >= IFW) ? (SFW - IFW) : 0;
    localparam int DR = (IFW > SFW) ? (IFW - SFW) : 0;
    localparam int HS = (DR > 0) ? (DR - 1) : 0;
    // Two spare bits on top of the accumulator keep the magnitude and the
    // half-LSB add clear of the sign position.
    localparam int RW = AW + 2 + SH;
    localparam logic [RW-1:0] HALF = (DR > 0) ? (RW'(1) << HS) : '0;
    localparam logic [RW-1:0] MINM = RW'(1) << (OW - 1);
    localparam logic [RW-1:0] MAXM = MINM - RW'(1);

    typedef enum logic {IDLE, ACC} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   sum_q, sum_d;
    logic            out_vld_q, out_vld_d;

    logic [AW-1:0]   samp;
    logic [AW-1:0]   total;
    logic            neg;
    logic [RW-1:0]   rmag;

    // Bring a sample of any mode into two's complement at accumulator width.
    function automatic logic [AW-1:0] to_acc(input logic [IW-1:0] a);
        logic [AW-1:0] m;
        if (SN == 0) begin
            to_acc = {{(AW-IW){1'b0}}, a};
        end else if (SN == 1) begin
            to_acc = {{(AW-IW){a[IW-1]}}, a};
        end else begin
            m = {{(AW-IW+1){1'b0}}, a[IW-2:0]};
            to_acc = a[IW-1] ? (~m + AW'(1)) : m;
        end
    endfunction

    // Rounded magnitude of a two's-complement total. Rounding the magnitude
    // upward on a half gives the away-from-zero rule for both signs.
    function automatic logic [RW-1:0] rnd_mag(input logic [AW-1:0] t);
        logic [RW-1:0] ext;
        logic [RW-1:0] mag;
        ext = {{(RW-AW){t[AW-1]}}, t};
        mag = ext[RW-1] ? (~ext + RW'(1)) : ext;
        if (SH > 0) rnd_mag = mag << SH;
        else        rnd_mag = (mag + HALF) >> DR;
    endfunction

    // Modular packing into the output format.
    function automatic logic [OW-1:0] wrap_out(input logic n, input logic [RW-1:0] m);
        logic [RW-1:0] r;
        if (SN == 0) begin
            wrap_out = m[OW-1:0];
        end else if (SN == 1) begin
            r = n ? (~m + RW'(1)) : m;
            wrap_out = r[OW-1:0];
        end else begin
            // A zero magnitude never carries a sign.
            wrap_out = {n & (m[OW-2:0] != '0), m[OW-2:0]};
        end
    endfunction

`ifdef FX_PT_SAT_EN
    function automatic logic out_of_range(input logic n, input logic [RW-1:0] m);
        if (SN == 0)      out_of_range = (m >> OW) != '0;
        else if (SN == 1) out_of_range = n ? (m > MINM) : (m > MAXM);
        else              out_of_range = m > MAXM;
    endfunction

    function automatic logic [OW-1:0] sat_out(input logic n);
        if (SN == 0)      sat_out = '1;
        else if (SN == 1) sat_out = n ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else              sat_out = {n, {(OW-1){1'b1}}};
    endfunction

    logic ovf_q, ovf_d;
`endif

    assign samp  = to_acc(in_a);
    assign total = acc_q + samp;
    assign neg   = (SN != 0) && total[AW-1];
    assign rmag  = rnd_mag(total);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        out_vld_d = 1'b0;
`ifdef FX_PT_SAT_EN
        ovf_d     = ovf_q;
`endif
        if (clr) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (in_vld) begin
            case (state_q)
                IDLE: begin
                    acc_d   = samp;
                    cnt_d   = CW'(1);
                    state_d = ACC;
                end
                ACC: begin
                    if (cnt_q == CW'(N - 1)) begin
`ifdef FX_PT_SAT_EN
                        ovf_d = out_of_range(neg, rmag);
                        sum_d = ovf_d ? sat_out(neg) : wrap_out(neg, rmag);
`else
                        sum_d = wrap_out(neg, rmag);
`endif
                        out_vld_d = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        acc_d = total;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            out_vld_q <= 1'b0;
`ifdef FX_PT_SAT_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            out_vld_q <= out_vld_d;
`ifdef FX_PT_SAT_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign sum     = sum_q;
    assign out_vld = out_vld_q;
    assign busy    = (state_q == ACC);
`ifdef FX_PT_SAT_EN
    assign ovf     = ovf_q;
`else
    assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_fx_pt_acc_rnd_reg.sv
// Directed bench for fx_pt_acc_rnd_reg: N=4, IIW=4, IFW=8, SFW=3.
// Three instances share the input stimulus:
//   u_tc  SN=1, SIW=7 (main), u_sm SN=2, SIW=7, u_nw SN=1, SIW=4 (narrow output).

module tb_fx_pt_acc_rnd_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_vld = 1'b0;
    logic [11:0] in_a = '0;

    logic [9:0]  tc_sum, sm_sum;
    logic [6:0]  nw_sum;
    logic        tc_vld, sm_vld, nw_vld;
    logic        tc_busy, sm_busy, nw_busy;
    logic        tc_ovf, sm_ovf, nw_ovf;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fx_pt_acc_rnd_reg #(.SN(1), .IIW(4), .IFW(8), .N(4), .SIW(7), .SFW(3)) u_tc (
        .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_a(in_a),
        .sum(tc_sum), .out_vld(tc_vld), .busy(tc_busy), .ovf(tc_ovf));

    fx_pt_acc_rnd_reg #(.SN(2), .IIW(4), .IFW(8), .N(4), .SIW(7), .SFW(3)) u_sm (
        .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_a(in_a),
        .sum(sm_sum), .out_vld(sm_vld), .busy(sm_busy), .ovf(sm_ovf));

    fx_pt_acc_rnd_reg #(.SN(1), .IIW(4), .IFW(8), .N(4), .SIW(4), .SFW(3)) u_nw (
        .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_a(in_a),
        .sum(nw_sum), .out_vld(nw_vld), .busy(nw_busy), .ovf(nw_ovf));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of input, then sample outputs 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [11:0] a, input logic c);
        in_vld = v;
        in_a   = a;
        clr    = c;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [11:0] a0, input logic [11:0] a1,
                         input logic [11:0] a2, input logic [11:0] a3, input logic [9:0] exp);
        cyc(1'b1, a0, 1'b0);
        cyc(1'b1, a1, 1'b0);
        cyc(1'b1, a2, 1'b0);
        check({tag, "_vld_pre"}, {31'd0, tc_vld}, 32'd0);
        cyc(1'b1, a3, 1'b0);
        check({tag, "_vld"}, {31'd0, tc_vld}, 32'd1);
        check({tag, "_sum"}, {22'd0, tc_sum}, {22'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", {22'd0, tc_sum}, 32'h0);
        check("rst_vld", {31'd0, tc_vld}, 32'd0);
        check("rst_busy", {31'd0, tc_busy}, 32'd0);
        check("rst_ovf", {31'd0, tc_ovf}, 32'd0);
        rst = 1'b0;

        // Basic: 4 x 0.5 -> 2.0
        frame("basic", 12'h080, 12'h080, 12'h080, 12'h080, 10'h010);
        check("basic_busy", {31'd0, tc_busy}, 32'd0);
        cyc(1'b0, 12'h000, 1'b0);
        check("basic_pulse", {31'd0, tc_vld}, 32'd0);
        check("basic_hold", {22'd0, tc_sum}, 32'h010);

        // Asynchronous reset mid-frame
        cyc(1'b1, 12'h100, 1'b0);
        cyc(1'b1, 12'h100, 1'b0);
        check("mid_busy", {31'd0, tc_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_sum", {22'd0, tc_sum}, 32'h0);
        check("arst_busy", {31'd0, tc_busy}, 32'd0);
        check("arst_vld", {31'd0, tc_vld}, 32'd0);
        #2;
        rst = 1'b0;
        frame("post_rst", 12'h080, 12'h080, 12'h080, 12'h080, 10'h010);

        // Rounding ties and signs
        frame("tie_pos", 12'h010, 12'h000, 12'h000, 12'h000, 10'h001);
        frame("tie_neg", 12'hFF0, 12'h000, 12'h000, 12'h000, 10'h3FF);
        frame("sm_tie", 12'h808, 12'h000, 12'h000, 12'h000, 10'h3C0);
        check("sm_noneg0", {22'd0, sm_sum}, 32'h000);
        frame("sm_neg", 12'h880, 12'h000, 12'h000, 12'h000, 10'h3C4);
        check("sm_neg_sum", {22'd0, sm_sum}, 32'h204);

        // Gaps between samples
        cyc(1'b1, 12'h080, 1'b0);
        cyc(1'b0, 12'h000, 1'b0);
        cyc(1'b0, 12'h000, 1'b0);
        check("gap_busy", {31'd0, tc_busy}, 32'd1);
        cyc(1'b1, 12'h080, 1'b0);
        cyc(1'b0, 12'h000, 1'b0);
        cyc(1'b1, 12'h080, 1'b0);
        check("gap_vld_pre", {31'd0, tc_vld}, 32'd0);
        cyc(1'b1, 12'h080, 1'b0);
        check("gap_vld", {31'd0, tc_vld}, 32'd1);
        check("gap_sum", {22'd0, tc_sum}, 32'h010);

        // clr after two samples
        cyc(1'b1, 12'h100, 1'b0);
        cyc(1'b1, 12'h100, 1'b0);
        cyc(1'b0, 12'h000, 1'b1);
        check("clr_busy", {31'd0, tc_busy}, 32'd0);
        frame("post_clr", 12'h080, 12'h080, 12'h080, 12'h080, 10'h010);

        // clr and in_vld together: sample dropped
        cyc(1'b1, 12'h100, 1'b1);
        check("clrv_busy", {31'd0, tc_busy}, 32'd0);
        frame("clrv", 12'h040, 12'h040, 12'h040, 12'h040, 10'h008);

        // clr on the Nth sample: no output
        cyc(1'b1, 12'h080, 1'b0);
        cyc(1'b1, 12'h080, 1'b0);
        cyc(1'b1, 12'h080, 1'b0);
        cyc(1'b1, 12'h080, 1'b1);
        check("clrn_vld", {31'd0, tc_vld}, 32'd0);
        check("clrn_hold", {22'd0, tc_sum}, 32'h008);
        check("clrn_busy", {31'd0, tc_busy}, 32'd0);

        // Back-to-back frames, no bubble
        frame("b2b_1", 12'h100, 12'h100, 12'h100, 12'h100, 10'h020);
        cyc(1'b1, 12'h100, 1'b0);
        check("b2b_gap_vld", {31'd0, tc_vld}, 32'd0);
        check("b2b_gap_busy", {31'd0, tc_busy}, 32'd1);
        cyc(1'b1, 12'h100, 1'b0);
        cyc(1'b1, 12'h100, 1'b0);
        cyc(1'b1, 12'h100, 1'b0);
        check("b2b_2_vld", {31'd0, tc_vld}, 32'd1);
        check("b2b_2_sum", {22'd0, tc_sum}, 32'h020);

        // Overflow on the narrow instance
        frame("ovf_wide", 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 10'h100);
        check("ovf_wide_flag", {31'd0, tc_ovf}, 32'd0);
`ifdef FX_PT_SAT_EN
        check("ovf_nw_sum", {25'd0, nw_sum}, 32'h3F);
        check("ovf_nw_flag", {31'd0, nw_ovf}, 32'd1);
`else
        check("ovf_nw_sum", {25'd0, nw_sum}, 32'h00);
        check("ovf_nw_flag", {31'd0, nw_ovf}, 32'd0);
`endif
        check("ovf_nw_vld", {31'd0, nw_vld}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
